sa_ram_rwsthp_param: RTL and testbench

- Parametrised 1R1W synchronous RAM model for FPGA builds of the small config. Generalises the fixed-size rwsthp RAMs (e.g. 60x42) to any DEPTH/WIDTH.
- Keeps the registered read address, output bypass mux and `ore`-gated output register.
- Adds:
  - per-chunk write mask
  - selectable output-register stage
  - read-valid tracking
  - out-of-range address detection

---
 rtl/sa_ram_pkg.sv | 21 ++
 rtl/sa_ram_outstage.sv | 46 ++++
 rtl/sa_ram_rwsthp_param.sv | 87 ++++++++
 tb/tb_sa_ram_rwsthp_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_ram_pkg.sv
// Shared sizing helpers and default geometry for the parametrised 1R1W RAM model.
package sa_ram_pkg;

  localparam int unsigned SA_RAM_DEPTH_DFLT = 60;
  localparam int unsigned SA_RAM_WIDTH_DFLT = 42;

  // Address width for n words, never below 1 bit.
  function automatic int unsigned sa_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned sa_mask_w(input int unsigned width, input int unsigned gran);
    return (width + gran - 1) / gran;
  endfunction

endpackage

// File: rtl/sa_ram_outstage.sv
// Read output stage: bypass mux, optional ore-gated data register and read-valid tracking.
module sa_ram_outstage #(
  parameter int unsigned WIDTH   = 42,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rd_pend,
  input  logic             ore,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  input  logic [WIDTH-1:0] dout_ram,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld
);

  logic [WIDTH-1:0] fdata;

  assign fdata = byp_sel ? dbyp : dout_ram;

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] dout_r;
    logic             vld_r;

    // An uncaptured pending read is dropped when ore is low.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_r <= '0;
        vld_r  <= 1'b0;
      end else if (ore) begin
        dout_r <= fdata;
        vld_r  <= rd_pend;
      end
    end

    assign dout     = dout_r;
    assign dout_vld = vld_r;
  end else begin : g_comb
    logic unused_sink;

    assign unused_sink = ore ^ clk ^ rstn;
    assign dout        = fdata;
    assign dout_vld    = rd_pend;
  end

endmodule

// File: rtl/sa_ram_rwsthp_param.sv
// Parametrised 1R1W synchronous RAM: masked write, registered read address,
// bypass/output stage and out-of-range address flagging.
module sa_ram_rwsthp_param
  import sa_ram_pkg::*;
#(
  parameter  int unsigned DEPTH     = SA_RAM_DEPTH_DFLT,
  parameter  int unsigned WIDTH     = SA_RAM_WIDTH_DFLT,
  parameter  int unsigned MASK_GRAN = 8,
  parameter  int unsigned OUT_REG   = 1,
  localparam int unsigned AW        = sa_clog2(DEPTH),
  localparam int unsigned MW        = sa_mask_w(WIDTH, MASK_GRAN)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [MW-1:0]    wmask,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  output logic             err_oob,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wbit;
  logic [WIDTH-1:0] dout_ram;
  logic [AW-1:0]    ra_d;
  logic             rd_pend;
  logic             wa_oob;
  logic             ra_oob;
  logic             rd_oob;
  logic             unused_pwr;

  assign unused_pwr = ^pwrbus_ram_pd;

  assign wa_oob = 32'(wa) >= DEPTH;
  assign ra_oob = 32'(ra) >= DEPTH;
  assign rd_oob = 32'(ra_d) >= DEPTH;

  // Expand chunk enables to per-bit enables; the last chunk may be partial.
  for (genvar b = 0; b < WIDTH; b++) begin : g_wbit
    assign wbit[b] = wmask[b / MASK_GRAN];
  end

  always_ff @(posedge clk) begin
    if (we && !wa_oob) begin
      mem[wa] <= (mem[wa] & ~wbit) | (di & wbit);
    end
  end

  // Combinational array read after the address register gives write-first behaviour.
  assign dout_ram = rd_oob ? '0 : mem[ra_d];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ra_d    <= '0;
      rd_pend <= 1'b0;
      err_oob <= 1'b0;
    end else begin
      rd_pend <= re;
      if (re) ra_d <= ra;
      err_oob <= (we && wa_oob) || (re && ra_oob);
    end
  end

  sa_ram_outstage #(
    .WIDTH   (WIDTH),
    .OUT_REG (OUT_REG)
  ) u_outstage (
    .clk      (clk),
    .rstn     (rstn),
    .rd_pend  (rd_pend),
    .ore      (ore),
    .byp_sel  (byp_sel),
    .dbyp     (dbyp),
    .dout_ram (dout_ram),
    .dout     (dout),
    .dout_vld (dout_vld)
  );

endmodule

// File: tb/tb_sa_ram_rwsthp_param.sv
// Bench for sa_ram_rwsthp_param: registered (OUT_REG=1) and direct (OUT_REG=0) builds
// driven in parallel and compared against a word-level memory model.
module tb_sa_ram_rwsthp_param;

  localparam int unsigned D  = 60;
  localparam int unsigned W  = 42;
  localparam int unsigned G  = 8;
  localparam int unsigned MW = 6;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] ra, wa;
  logic          re, ore, we, byp_sel;
  logic [W-1:0]  di, dbyp;
  logic [MW-1:0] wmask;
  logic [31:0]   pwr;
  logic [W-1:0]  dout1, dout0;
  logic          vld1, vld0, err1, err0;

  always #5 clk = ~clk;

  sa_ram_rwsthp_param #(.OUT_REG(1)) u_dut (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
    .wa(wa), .we(we), .di(di), .wmask(wmask), .byp_sel(byp_sel), .dbyp(dbyp),
    .err_oob(err1), .pwrbus_ram_pd(pwr)
  );

  sa_ram_rwsthp_param #(.OUT_REG(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
    .wa(wa), .we(we), .di(di), .wmask(wmask), .byp_sel(byp_sel), .dbyp(dbyp),
    .err_oob(err0), .pwrbus_ram_pd(pwr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: memory contents plus the word the read path should present.
  logic [W-1:0]  m_mem [D];
  logic [AW-1:0] m_addr;
  logic          m_pend;
  logic [W-1:0]  m_dout;
  logic          m_vld;
  logic          m_err;
  bit            chk_on = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (32'(a) < D) return m_mem[a];
    return '0;
  endfunction

  function automatic logic [W-1:0] chunk_bits(input logic [MW-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < int'(MW); c++) begin
      if (m[c]) begin
        for (int b = c * int'(G); b < (c + 1) * int'(G) && b < int'(W); b++) r[b] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_addr = '0;
    m_pend = 1'b0;
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare both builds.
  task automatic tick();
    logic [W-1:0] wbits;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else begin
      if (ore) begin
        m_dout = byp_sel ? dbyp : m_read(m_addr);
        m_vld  = m_pend;
      end
      m_err  = (we && 32'(wa) >= D) || (re && 32'(ra) >= D);
      m_pend = re;
      if (re) m_addr = ra;
    end
    if (we && 32'(wa) < D) begin
      wbits = chunk_bits(wmask);
      m_mem[wa] = (m_mem[wa] & ~wbits) | (di & wbits);
    end
    #1;
    if (chk_on) begin
      check("dout",     dout1,   m_dout);
      check("dout_vld", W'(vld1), W'(m_vld));
      check("err_oob",  W'(err1), W'(m_err));
      check("dout0",    dout0,   byp_sel ? dbyp : m_read(m_addr));
      check("dout_vld0", W'(vld0), W'(m_pend));
      check("err_oob0", W'(err0), W'(m_err));
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    re = 1'b0; ore = 1'b0; we = 1'b0; byp_sel = 1'b0;
    ra = '0; wa = '0; di = '0; dbyp = '0; wmask = '0;
  endtask

  int addrs [4] = '{3, 10, 20, 30};

  initial begin
    rstn = 1'b0;
    pwr  = $urandom();
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_dout",  dout1, '0);
    check("rst_vld",   W'(vld1), '0);
    check("rst_err",   W'(err1), '0);
    check("rst_vld0",  W'(vld0), '0);
    check("rst_err0",  W'(err0), '0);
    rstn = 1'b1;

    // Fill the array so every later read is defined.
    for (int a = 0; a < int'(D); a++) begin
      we = 1'b1; wa = AW'(a); di = rnd_w(); wmask = '1;
      tick();
    end
    we = 1'b0;
    chk_on = 1'b1;

    // Full-mask write, read, then ore capture.
    we = 1'b1; wa = 6'd5; di = 42'h3_FFFF_FFFF_FF; wmask = 6'h3F;
    tick();
    we = 1'b0; re = 1'b1; ra = 6'd5;
    tick();
    check("t1_pre_dout", dout1, '0);
    check("t1_pre_vld",  W'(vld1), '0);
    re = 1'b0; ore = 1'b1;
    tick();
    check("t1_dout", dout1, 42'h3_FFFF_FFFF_FF);
    check("t1_vld",  W'(vld1), W'(1'b1));

    // Partial mask including the 2-bit top chunk.
    ore = 1'b0;
    we = 1'b1; wa = 6'd7; di = '0; wmask = 6'h3F;
    tick();
    di = '1; wmask = 6'b100001;
    tick();
    we = 1'b0; re = 1'b1; ra = 6'd7;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    check("t2_dout", dout1, 42'h3_0000_0000_FF);

    // Same-edge write/read returns new data; the following write does not leak in.
    ore = 1'b0;
    we = 1'b1; wa = 6'd9; di = 42'h155; wmask = '1; re = 1'b1; ra = 6'd9;
    tick();
    re = 1'b0; di = 42'h0AA; ore = 1'b1;
    tick();
    check("t3_dout", dout1, 42'h155);
    check("t3_vld",  W'(vld1), W'(1'b1));
    we = 1'b0;

    // Bypass selected at capture, then hold with ore low.
    ore = 1'b0; re = 1'b1; ra = 6'd59;
    tick();
    re = 1'b0; ore = 1'b1; byp_sel = 1'b1; dbyp = 42'h2A;
    tick();
    check("t4_dout", dout1, 42'h2A);
    ore = 1'b0; byp_sel = 1'b0; dbyp = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_dout", dout1, 42'h2A);
      check("t4_hold_vld",  W'(vld1), W'(1'b1));
    end

    // Out-of-range write and read.
    we = 1'b1; wa = 6'd60; di = rnd_w(); wmask = '1;
    tick();
    check("t5_werr", W'(err1), W'(1'b1));
    we = 1'b0;
    tick();
    check("t5_werr_clr", W'(err1), '0);
    re = 1'b1; ra = 6'd63;
    tick();
    check("t5_rerr", W'(err0), W'(1'b1));
    re = 1'b0; ore = 1'b1;
    tick();
    check("t5_rerr_clr", W'(err1), '0);
    check("t5_dout", dout1, '0);
    check("t5_vld",  W'(vld1), W'(1'b1));

    // Sweep every word back out.
    for (int a = 0; a < int'(D); a++) begin
      re = 1'b1; ra = AW'(a);
      tick();
    end
    re = 1'b0;
    tick();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      we      = 1'($urandom_range(0, 1));
      wa      = AW'($urandom_range(0, 63));
      di      = rnd_w();
      wmask   = MW'($urandom());
      re      = 1'($urandom_range(0, 1));
      ra      = AW'($urandom_range(0, 63));
      ore     = ($urandom_range(0, 3) != 0);
      byp_sel = ($urandom_range(0, 7) == 0);
      dbyp    = rnd_w();
      tick();
    end
    idle_inputs();
    tick();

    // Direct-output build streams reads, then reset lands mid-stream.
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; ra = AW'(addrs[i]);
      tick();
      check("t6_dout0", dout0, m_mem[addrs[i]]);
      check("t6_vld0",  W'(vld0), W'(1'b1));
    end
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("t6_rst_vld0", W'(vld0), '0);
    check("t6_rst_vld",  W'(vld1), '0);
    re = 1'b0;
    @(negedge clk);
    tick();
    rstn = 1'b1;
    tick();
    check("t6_post_vld0", W'(vld0), '0);
    check("t6_post_vld",  W'(vld1), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
